// File: rtl/krnl_cbc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// krnl_cbc_pkg : shared types and constants for the CBC kernel job sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package krnl_cbc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WORD_BYTES           = 16;
  localparam int WORD_SHIFT           = $clog2(WORD_BYTES);
  localparam int BURST_WORDS_DEF      = 16;
  localparam int LOG2_BURST_WORDS_DEF = $clog2(BURST_WORDS_DEF);

endpackage
`default_nettype wire

// File: rtl/krnl_cbc_burst_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// krnl_cbc_burst_gen : byte address and length-minus-one of burst i_idx
// Rev 1.0
// ----------------------------------------------------------------------------
module krnl_cbc_burst_gen
  import krnl_cbc_pkg::*;
#(
  parameter int BURST_WORDS = BURST_WORDS_DEF
) (
  input  logic [63:0] i_base,
  input  logic [31:0] i_idx,
  input  logic [31:0] i_total,
  input  logic [31:0] i_words,
  output logic [63:0] o_addr,
  output logic [7:0]  o_len
);

  localparam int          C_SHIFT = $clog2(BURST_WORDS) + WORD_SHIFT;
  localparam logic [31:0] C_MASK  = 32'(BURST_WORDS - 1);

  logic w_last;

  assign w_last = (i_idx == (i_total - 32'd1));
  // 64-bit add wraps silently past the top of the address space
  assign o_addr = i_base + ({32'd0, i_idx} << C_SHIFT);
  assign o_len  = w_last ? 8'((i_words - 32'd1) & C_MASK) : 8'(C_MASK);

endmodule
`default_nettype wire

// File: rtl/krnl_cbc_job_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// krnl_cbc_job_ctrl : ap_ctrl_chain job sequencer issuing bounded read/write bursts
// Rev 1.0
// ----------------------------------------------------------------------------
module krnl_cbc_job_ctrl
  import krnl_cbc_pkg::*;
#(
  parameter int BURST_WORDS     = BURST_WORDS_DEF,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        ap_start,
  input  logic        ap_continue,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [63:0] src_addr,
  input  logic [63:0] dest_addr,
  input  logic [31:0] words_num,
  output logic        rd_req_valid,
  input  logic        rd_req_ready,
  output logic [63:0] rd_req_addr,
  output logic [7:0]  rd_req_len,
  output logic        wr_req_valid,
  input  logic        wr_req_ready,
  output logic [63:0] wr_req_addr,
  output logic [7:0]  wr_req_len,
  input  logic        wr_resp_valid
);

  localparam int C_LOG2_BW = $clog2(BURST_WORDS);

  state_t      r_state, w_state_nxt;
  logic [63:0] r_src, r_dest, w_src_nxt, w_dest_nxt;
  logic [31:0] r_words, r_total, w_words_nxt, w_total_nxt;
  logic [31:0] r_rd_cnt, r_wr_cnt, r_resp_cnt, w_rd_nxt, w_wr_nxt, w_resp_nxt;
  logic        w_capture, w_rd_hs, w_wr_hs, w_resp;
  logic [63:0] w_rd_addr, w_wr_addr;
  logic [7:0]  w_rd_len, w_wr_len;
  logic        w_ready_nxt, w_idle_nxt, w_done_nxt, w_rd_valid_nxt, w_wr_valid_nxt;

  assign w_capture = (r_state == IDLE) && ap_start;
  assign w_rd_hs   = rd_req_valid && rd_req_ready;
  assign w_wr_hs   = wr_req_valid && wr_req_ready;
  assign w_resp    = (r_state == RUN) && wr_resp_valid && (r_resp_cnt != r_total);

  // Outputs are registered from next-cycle values so requests appear the cycle after capture
  assign w_src_nxt   = w_capture ? src_addr  : r_src;
  assign w_dest_nxt  = w_capture ? dest_addr : r_dest;
  assign w_words_nxt = w_capture ? words_num : r_words;
  assign w_total_nxt = w_capture ?
      32'(({1'b0, words_num} + 33'(BURST_WORDS - 1)) >> C_LOG2_BW) : r_total;
  assign w_rd_nxt    = w_capture ? 32'd0 : r_rd_cnt   + 32'(w_rd_hs);
  assign w_wr_nxt    = w_capture ? 32'd0 : r_wr_cnt   + 32'(w_wr_hs);
  assign w_resp_nxt  = w_capture ? 32'd0 : r_resp_cnt + 32'(w_resp);

  krnl_cbc_burst_gen #(.BURST_WORDS(BURST_WORDS)) u_rd_gen (
    .i_base (w_src_nxt),
    .i_idx  (w_rd_nxt),
    .i_total(w_total_nxt),
    .i_words(w_words_nxt),
    .o_addr (w_rd_addr),
    .o_len  (w_rd_len)
  );

  krnl_cbc_burst_gen #(.BURST_WORDS(BURST_WORDS)) u_wr_gen (
    .i_base (w_dest_nxt),
    .i_idx  (w_wr_nxt),
    .i_total(w_total_nxt),
    .i_words(w_words_nxt),
    .o_addr (w_wr_addr),
    .o_len  (w_wr_len)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // A zero-length job passes through RUN for one cycle without issuing requests
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ap_start) w_state_nxt = RUN;
      RUN:     if (w_resp_nxt == r_total) w_state_nxt = DONE;
      DONE:    if (ap_continue) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ready_nxt    = w_capture;
    w_idle_nxt     = (w_state_nxt == IDLE);
    w_done_nxt     = (w_state_nxt == DONE);
    w_rd_valid_nxt = (w_state_nxt == RUN) && (w_rd_nxt < w_total_nxt) &&
                     ((w_rd_nxt - w_resp_nxt) < 32'(MAX_OUTSTANDING));
    w_wr_valid_nxt = (w_state_nxt == RUN) && (w_wr_nxt < w_rd_nxt);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_src      <= '0;
      r_dest     <= '0;
      r_words    <= '0;
      r_total    <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_resp_cnt <= '0;
    end else begin
      r_src      <= w_src_nxt;
      r_dest     <= w_dest_nxt;
      r_words    <= w_words_nxt;
      r_total    <= w_total_nxt;
      r_rd_cnt   <= w_rd_nxt;
      r_wr_cnt   <= w_wr_nxt;
      r_resp_cnt <= w_resp_nxt;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ap_ready     <= 1'b0;
      ap_idle      <= 1'b1;
      ap_done      <= 1'b0;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_len   <= '0;
      wr_req_valid <= 1'b0;
      wr_req_addr  <= '0;
      wr_req_len   <= '0;
    end else begin
      ap_ready     <= w_ready_nxt;
      ap_idle      <= w_idle_nxt;
      ap_done      <= w_done_nxt;
      rd_req_valid <= w_rd_valid_nxt;
      rd_req_addr  <= w_rd_valid_nxt ? w_rd_addr : 64'd0;
      rd_req_len   <= w_rd_valid_nxt ? w_rd_len  : 8'd0;
      wr_req_valid <= w_wr_valid_nxt;
      wr_req_addr  <= w_wr_valid_nxt ? w_wr_addr : 64'd0;
      wr_req_len   <= w_wr_valid_nxt ? w_wr_len  : 8'd0;
    end
  end

endmodule
`default_nettype wire
